// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: widths, buffer depth,
// PC increment and the fetch FSM encoding.
package inst_fetch_pkg;

    localparam int XLEN            = 32;
    localparam int FETCH_BUF_DEPTH = 2;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_buf.sv
// Two-entry instruction FIFO holding {instruction word, fetch address}.
// Flush takes priority over push and pop in the same cycle.
module fetch_buf
    import inst_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push,
    input  logic [XLEN-1:0] push_data,
    input  logic [XLEN-1:0] push_pc,
    input  logic            pop,
    output logic [XLEN-1:0] head_data,
    output logic [XLEN-1:0] head_pc,
    output logic [1:0]      count
);

    logic [XLEN-1:0] data_q [FETCH_BUF_DEPTH];
    logic [XLEN-1:0] pc_q   [FETCH_BUF_DEPTH];
    logic            rd_ptr;
    logic            wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_pop  = pop && (count != 2'd0);
    // A push into a full buffer is only legal when the head leaves this cycle.
    assign do_push = push && ((count != 2'(FETCH_BUF_DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                data_q[wr_ptr] <= push_data;
                pc_q[wr_ptr]   <= push_pc;
                wr_ptr         <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = data_q[rd_ptr];
    assign head_pc   = pc_q[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: single-outstanding memory requester feeding a 2-entry buffer,
// with redirect (pc_load) flushing the buffer and discarding in-flight responses.
//
// state    | meaning
// ST_IDLE  | one cycle after reset release, no request
// ST_FETCH | request at fetch PC while buffer has room after this cycle's pop
// ST_WAIT  | one request granted, waiting for mem_rvalid (dropped if discard set)
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_load,
    input  logic [XLEN-1:0] pc_target,
    input  logic            stall,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] rdata,
    output logic            rdata_valid,
    output logic [XLEN-1:0] rdata_pc
);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
    logic [XLEN-1:0] req_pc, req_pc_nxt;
    logic            discard, discard_nxt;
    logic [1:0]      buf_count;
    logic [1:0]      count_after;
    logic            pop;
    logic            push;

    fetch_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (pc_load),
        .push      (push),
        .push_data (mem_rdata),
        .push_pc   (req_pc),
        .pop       (pop),
        .head_data (rdata),
        .head_pc   (rdata_pc),
        .count     (buf_count)
    );

    assign rdata_valid = (buf_count != 2'd0);
    assign pop         = rdata_valid && !stall;
    // Issue decision looks at occupancy after this cycle's pop.
    assign count_after = buf_count - {1'b0, pop};
    assign mem_addr    = fetch_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            fetch_pc <= word_align(RESET_PC);
            req_pc   <= '0;
            discard  <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            req_pc   <= req_pc_nxt;
            discard  <= discard_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        req_pc_nxt   = req_pc;
        discard_nxt  = discard;
        mem_req      = 1'b0;
        push         = 1'b0;

        case (state)
            ST_IDLE: begin
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = (count_after < 2'(FETCH_BUF_DEPTH));
                if (mem_req && mem_gnt) begin
                    req_pc_nxt   = fetch_pc;
                    fetch_pc_nxt = fetch_pc + PC_STEP;
                    state_nxt    = ST_WAIT;
                    discard_nxt  = pc_load;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    push        = !discard && !pc_load;
                    discard_nxt = 1'b0;
                    state_nxt   = ST_FETCH;
                end else if (pc_load) begin
                    discard_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Redirect overrides any increment from a same-cycle grant.
        if (pc_load) begin
            fetch_pc_nxt = word_align(pc_target);
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: memory model plus scoreboard of expected
// buffer contents and issue addresses, directed redirect table and random traffic.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int MODE_GRANT  = 0;
    localparam int MODE_WAIT   = 1;
    localparam int MODE_NOGNT  = 2;
    localparam int MODE_RVALID = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_target = '0;
    logic        stall = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic [31:0] rdata_pc;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .rdata_pc    (rdata_pc)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    typedef struct {
        int          mode;
        int          skip;
        int          lat;
        logic [31:0] target;
        logic [31:0] exp_pc;
    } vec_t;

    entry_t      buf_q[$];
    logic [31:0] inflight[$];
    logic [31:0] grant_log[$];
    logic [31:0] exp_pc;
    int          n_pass = 0;
    int          n_total = 0;

    bit          gnt_en = 1'b1;
    bit          mem_pending = 1'b0;
    bit          stale_rv = 1'b0;
    int          rv_lat = 1;
    int          mem_cnt = 0;
    logic [31:0] pend_addr = '0;
    bit          watch_valid = 1'b0;
    logic [31:0] first_valid_pc = '0;
    int          load_idx = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'hC0DE_5A5A) + 32'h0101_0101;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    task automatic tick_begin();
        mem_gnt    = gnt_en && !mem_pending;
        mem_rvalid = (mem_pending && mem_cnt == 1) || stale_rv;
        mem_rdata  = stale_rv ? 32'hDEAD_BEEF : (mem_rvalid ? mem_word(pend_addr) : 32'h0);
        #1;
    endtask

    task automatic tick_end();
        bit     popped;
        int     after;
        entry_t e;
        #1;
        if (watch_valid && rdata_valid) begin
            first_valid_pc = rdata_pc;
            watch_valid    = 1'b0;
        end
        chk("rdata_valid", 32'(rdata_valid), 32'(buf_q.size() != 0));
        if (buf_q.size() != 0) begin
            chk("rdata_pc", rdata_pc, buf_q[0].pc);
            chk("rdata", rdata, buf_q[0].data);
        end
        popped = rdata_valid && !stall && (buf_q.size() != 0);
        after  = buf_q.size() - (popped ? 1 : 0);
        chk("issue_gate", 32'(mem_req && (after >= 2)), 32'd0);
        chk("one_outstanding", 32'(mem_req && (inflight.size() != 0)), 32'd0);
        if (popped) void'(buf_q.pop_front());
        if (mem_rvalid && mem_pending) begin
            if (inflight.size() != 0) begin
                e.pc   = inflight.pop_front();
                e.data = mem_rdata;
                buf_q.push_back(e);
            end
            mem_pending = 1'b0;
        end else if (mem_pending) begin
            mem_cnt--;
        end
        if (mem_req && mem_gnt) begin
            chk("mem_addr", mem_addr, exp_pc);
            grant_log.push_back(mem_addr);
            inflight.push_back(exp_pc);
            exp_pc      = exp_pc + 32'd4;
            mem_pending = 1'b1;
            mem_cnt     = rv_lat;
            pend_addr   = mem_addr;
        end
        if (pc_load) begin
            buf_q.delete();
            inflight.delete();
            exp_pc      = {pc_target[31:2], 2'b00};
            watch_valid = 1'b1;
            load_idx    = grant_log.size();
        end
        @(posedge clk);
        @(negedge clk);
        pc_load  = 1'b0;
        stale_rv = 1'b0;
    endtask

    task automatic tick();
        tick_begin();
        tick_end();
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        pc_load     = 1'b0;
        buf_q.delete();
        inflight.delete();
        exp_pc      = RESET_PC;
        mem_pending = 1'b0;
        watch_valid = 1'b0;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, RESET_PC);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        chk("rst_rdata_pc", rdata_pc, 32'd0);
        tick();
        tick();
        rst = 1'b1;
    endtask

    function automatic bit cond_hit(input int mode);
        case (mode)
            MODE_GRANT:  return mem_req && mem_gnt;
            MODE_WAIT:   return mem_pending && !mem_rvalid;
            MODE_NOGNT:  return mem_req && !mem_gnt;
            default:     return mem_rvalid && mem_pending;
        endcase
    endfunction

    vec_t vecs[5];

    initial begin
        int  seen;
        int  hits;
        bit  found;
        bit  done;

        vecs[0] = '{MODE_GRANT,  1, 1, 32'h0000_0204, 32'h0000_0204};
        vecs[1] = '{MODE_WAIT,   0, 2, 32'h0000_0100, 32'h0000_0100};
        vecs[2] = '{MODE_NOGNT,  0, 1, 32'h0000_0FF3, 32'h0000_0FF0};
        vecs[3] = '{MODE_RVALID, 0, 3, 32'h0000_0400, 32'h0000_0400};
        vecs[4] = '{MODE_WAIT,   0, 2, 32'hFFFF_FFFC, 32'hFFFF_FFFC};

        @(negedge clk);
        do_reset();

        // Sequential streaming with a one-cycle memory.
        tick_begin();
        chk("idle_no_req", 32'(mem_req), 32'd0);
        tick_end();
        tick_begin();
        chk("fetch_req", 32'(mem_req), 32'd1);
        chk("first_addr", mem_addr, RESET_PC);
        tick_end();
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick_begin();
            if (rdata_valid && !stall) begin
                chk("stream_pc", rdata_pc, 32'(seen * 4));
                seen++;
            end
            tick_end();
        end
        chk("stream_count", 32'(seen), 32'd10);

        // Consumer stall fills the buffer, then release resumes at addr 8.
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        tick_begin();
        chk("stall_no_req", 32'(mem_req), 32'd0);
        chk("stall_valid", 32'(rdata_valid), 32'd1);
        chk("stall_head_pc", rdata_pc, 32'd0);
        tick_end();
        stall = 1'b0;
        load_idx = grant_log.size();
        for (int i = 0; i < 10 && grant_log.size() == load_idx; i++) tick();
        chk("resume_grant_seen", 32'(grant_log.size() > load_idx), 32'd1);
        if (grant_log.size() > load_idx) chk("resume_addr", grant_log[load_idx], 32'h8);

        // Redirect table.
        do_reset();
        for (int v = 0; v < 5; v++) begin
            rv_lat = vecs[v].lat;
            gnt_en = (vecs[v].mode != MODE_NOGNT);
            hits   = 0;
            found  = 1'b0;
            for (int c = 0; c < 40 && !found; c++) begin
                tick_begin();
                if (cond_hit(vecs[v].mode)) begin
                    if (hits == vecs[v].skip) begin
                        pc_load   = 1'b1;
                        pc_target = vecs[v].target;
                        found     = 1'b1;
                    end
                    hits++;
                end
                tick_end();
            end
            chk("vec_trigger", 32'(found), 32'd1);
            gnt_en = 1'b1;
            done   = 1'b0;
            for (int c = 0; c < 60 && !done; c++) begin
                tick();
                done = !watch_valid && (grant_log.size() >= load_idx + 2);
            end
            chk("vec_done", 32'(done), 32'd1);
            if (done) begin
                chk("vec_first_issue", grant_log[load_idx], vecs[v].exp_pc);
                chk("vec_second_issue", grant_log[load_idx + 1], vecs[v].exp_pc + 32'd4);
                chk("vec_first_valid_pc", first_valid_pc, vecs[v].exp_pc);
            end
        end

        // Reset while a response is outstanding; late rvalid must be ignored.
        rv_lat = 3;
        found  = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick_begin();
            found = mem_pending && !mem_rvalid;
            tick_end();
        end
        chk("rst_wait_trigger", 32'(found), 32'd1);
        do_reset();
        gnt_en = 1'b0;
        tick();
        stale_rv = 1'b1;
        tick_begin();
        chk("stale_addr", mem_addr, RESET_PC);
        tick_end();
        tick_begin();
        chk("stale_dropped", 32'(rdata_valid), 32'd0);
        tick_end();
        gnt_en      = 1'b1;
        watch_valid = 1'b1;
        for (int c = 0; c < 10 && watch_valid; c++) tick();
        chk("fresh_valid_seen", 32'(watch_valid), 32'd0);
        chk("fresh_valid_pc", first_valid_pc, RESET_PC);

        // Random traffic with occasional redirects.
        for (int c = 0; c < 400; c++) begin
            gnt_en = ($urandom_range(0, 3) != 0);
            stall  = ($urandom_range(0, 2) == 0);
            if (!mem_pending) rv_lat = $urandom_range(1, 3);
            if ($urandom_range(0, 24) == 0) begin
                pc_load   = 1'b1;
                pc_target = $urandom;
            end
            tick();
        end
        stall = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
